// File: rtl/result_reader_if.sv
// Handshake and bus bundle for result_reader: start request, memory read port,
// UART line and status flags. The design connects through the slave modport.
interface result_reader_if;
    logic        start;
    logic        mem_re;
    logic [12:0] mem_raddr;
    logic [7:0]  mem_dout;
    logic        tx;
    logic        busy;
    logic        done;

    modport slave (
        input  start,
        input  mem_dout,
        output mem_re,
        output mem_raddr,
        output tx,
        output busy,
        output done
    );

    modport master (
        output start,
        output mem_dout,
        input  mem_re,
        input  mem_raddr,
        input  tx,
        input  busy,
        input  done
    );
endinterface

// File: rtl/result_reader.sv
// Reads N_WORDS bytes from memory starting at BASE_ADDR and sends each as a UART 8N1 frame.
// Optional trailing XOR checksum frame when RESULT_READER_CHECKSUM_EN is defined.
module result_reader #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned BASE_ADDR    = 1,
    parameter int unsigned N_WORDS      = 8
) (
    input  logic           clk,
    input  logic           rst,
    result_reader_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP,
        S_NEXT
`ifdef RESULT_READER_CHECKSUM_EN
        ,
        S_CSUM
`endif
    } state_t;

    localparam logic [15:0] LP_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [12:0] LP_BASE = 13'(BASE_ADDR);
    localparam logic [13:0] LP_N    = 14'(N_WORDS);

    state_t      r_state, w_next;
    logic [15:0] r_timer, w_timer;
    logic [2:0]  r_bit_idx, w_bit_idx;
    logic [7:0]  r_shift, w_shift;
    logic [12:0] r_addr, w_addr;
    logic [13:0] r_cnt, w_cnt;
    logic        r_busy, w_busy;
    logic        r_done, w_done;
    logic        r_tx, w_tx;
    logic        w_bit_end;
`ifdef RESULT_READER_CHECKSUM_EN
    logic [7:0]  r_csum, w_csum;
    logic        r_csum_phase, w_csum_phase;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_addr       <= '0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_tx         <= 1'b1;
`ifdef RESULT_READER_CHECKSUM_EN
            r_csum       <= '0;
            r_csum_phase <= 1'b0;
`endif
        end else begin
            r_state      <= w_next;
            r_timer      <= w_timer;
            r_bit_idx    <= w_bit_idx;
            r_shift      <= w_shift;
            r_addr       <= w_addr;
            r_cnt        <= w_cnt;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_tx         <= w_tx;
`ifdef RESULT_READER_CHECKSUM_EN
            r_csum       <= w_csum;
            r_csum_phase <= w_csum_phase;
`endif
        end
    end

    always_comb begin
        w_next       = r_state;
        w_timer      = r_timer;
        w_bit_idx    = r_bit_idx;
        w_shift      = r_shift;
        w_addr       = r_addr;
        w_cnt        = r_cnt;
        w_busy       = r_busy;
        w_done       = 1'b0;
`ifdef RESULT_READER_CHECKSUM_EN
        w_csum       = r_csum;
        w_csum_phase = r_csum_phase;
`endif
        w_bit_end    = (r_timer == LP_LAST);

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_addr = LP_BASE;
                    w_cnt  = '0;
                    w_busy = 1'b1;
                    w_next = S_FETCH;
`ifdef RESULT_READER_CHECKSUM_EN
                    w_csum       = '0;
                    w_csum_phase = 1'b0;
`endif
                end
            end
            S_FETCH: w_next = S_WAIT;
            S_WAIT:  w_next = S_LOAD;
            S_LOAD: begin
                w_shift = bus.mem_dout;
`ifdef RESULT_READER_CHECKSUM_EN
                w_csum  = r_csum ^ bus.mem_dout;
`endif
                w_next  = S_START;
            end
            S_START: begin
                if (w_bit_end) begin
                    w_timer   = '0;
                    w_bit_idx = '0;
                    w_next    = S_DATA;
                end else begin
                    w_timer = r_timer + 16'd1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_timer = '0;
                    w_shift = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_next = S_STOP;
                    end else begin
                        w_bit_idx = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_timer = r_timer + 16'd1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_timer = '0;
                    w_next  = S_NEXT;
                end else begin
                    w_timer = r_timer + 16'd1;
                end
            end
            S_NEXT: begin
`ifdef RESULT_READER_CHECKSUM_EN
                // The checksum frame also ends through NEXT; only then is the readout complete.
                if (r_csum_phase) begin
                    w_done = 1'b1;
                    w_busy = 1'b0;
                    w_next = S_IDLE;
                end else begin
                    w_addr = r_addr + 13'd1;
                    w_cnt  = r_cnt + 14'd1;
                    w_next = (w_cnt == LP_N) ? S_CSUM : S_FETCH;
                end
`else
                w_addr = r_addr + 13'd1;
                w_cnt  = r_cnt + 14'd1;
                if (w_cnt == LP_N) begin
                    w_done = 1'b1;
                    w_busy = 1'b0;
                    w_next = S_IDLE;
                end else begin
                    w_next = S_FETCH;
                end
`endif
            end
`ifdef RESULT_READER_CHECKSUM_EN
            S_CSUM: begin
                w_shift      = r_csum;
                w_csum_phase = 1'b1;
                w_next       = S_START;
            end
`endif
            default: w_next = S_IDLE;
        endcase

        // tx is registered from the state being entered so the line changes on the state edge.
        w_tx = 1'b1;
        if (w_next == S_START) begin
            w_tx = 1'b0;
        end else if (w_next == S_DATA) begin
            w_tx = w_shift[0];
        end
    end

    assign bus.mem_re    = (r_state == S_FETCH);
    assign bus.mem_raddr = r_addr;
    assign bus.tx        = r_tx;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule

// File: tb/tb_result_reader.sv
// Directed bench for result_reader: three instances cover the basic readout,
// address wrap and minimum-parameter configurations; checksum-aware via RESULT_READER_CHECKSUM_EN.
module tb_result_reader;

`ifdef RESULT_READER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic clk;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic [7:0]  mem_a [0:8191];
    logic [7:0]  mem_w [0:8191];
    logic [7:0]  mem_m [0:8191];
    logic [12:0] addr_q0 [$];
    logic [12:0] addr_q1 [$];
    logic [12:0] addr_q2 [$];
    int          done_cnt [3];

    result_reader_if if_a ();
    result_reader_if if_w ();
    result_reader_if if_m ();

    result_reader #(.CLKS_PER_BIT(4), .BASE_ADDR(1), .N_WORDS(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );
    result_reader #(.CLKS_PER_BIT(4), .BASE_ADDR(8191), .N_WORDS(2)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (if_w)
    );
    result_reader #(.CLKS_PER_BIT(2), .BASE_ADDR(1), .N_WORDS(1)) dut_m (
        .clk (clk),
        .rst (rst),
        .bus (if_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous memory models: data appears one clock after mem_re and holds.
    always @(posedge clk) begin
        if (if_a.mem_re) if_a.mem_dout <= mem_a[if_a.mem_raddr];
        if (if_w.mem_re) if_w.mem_dout <= mem_w[if_w.mem_raddr];
        if (if_m.mem_re) if_m.mem_dout <= mem_m[if_m.mem_raddr];
    end

    always @(negedge clk) begin
        if (if_a.mem_re) addr_q0.push_back(if_a.mem_raddr);
        if (if_w.mem_re) addr_q1.push_back(if_w.mem_raddr);
        if (if_m.mem_re) addr_q2.push_back(if_m.mem_raddr);
        if (if_a.done === 1'b1) done_cnt[0]++;
        if (if_w.done === 1'b1) done_cnt[1]++;
        if (if_m.done === 1'b1) done_cnt[2]++;
    end

    function automatic logic get_tx(input int w);
        case (w)
            0:       return if_a.tx;
            1:       return if_w.tx;
            default: return if_m.tx;
        endcase
    endfunction

    function automatic logic get_done(input int w);
        case (w)
            0:       return if_a.done;
            1:       return if_w.done;
            default: return if_m.done;
        endcase
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            0:       return if_a.busy;
            1:       return if_w.busy;
            default: return if_m.busy;
        endcase
    endfunction

    function automatic logic get_re(input int w);
        case (w)
            0:       return if_a.mem_re;
            1:       return if_w.mem_re;
            default: return if_m.mem_re;
        endcase
    endfunction

    function automatic int addr_size(input int w);
        case (w)
            0:       return addr_q0.size();
            1:       return addr_q1.size();
            default: return addr_q2.size();
        endcase
    endfunction

    function automatic logic [12:0] addr_at(input int w, input int idx);
        case (w)
            0:       return addr_q0[idx];
            1:       return addr_q1[idx];
            default: return addr_q2[idx];
        endcase
    endfunction

    task automatic drive_start(input int w, input logic v);
        case (w)
            0:       if_a.start = v;
            1:       if_w.start = v;
            default: if_m.start = v;
        endcase
    endtask

    // Returns on the negedge of the first FETCH cycle; t is that cycle.
    task automatic pulse_start(input int w, output int t);
        @(negedge clk);
        drive_start(w, 1'b1);
        @(negedge clk);
        drive_start(w, 1'b0);
        t = cyc;
    endtask

    // Waits for a start bit, then checks every cycle of the 10-bit frame.
    task automatic check_frame(input int w, input int cpb, input logic [7:0] exp,
                               input string nm, output int t_start);
        int         n;
        int         errs;
        logic       eb;
        logic       txv;
        logic [7:0] got;
        n = 0;
        errs = 0;
        got = '0;
        while (get_tx(w) !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (get_tx(w) !== 1'b0) begin
            bad++;
            t_start = -1;
            $display("FAIL %s: no start bit seen, required frame %02h", nm, exp);
            return;
        end
        t_start = cyc;
        for (int k = 0; k < 10 * cpb; k++) begin
            if (k < cpb)          eb = 1'b0;
            else if (k < 9 * cpb) eb = exp[(k - cpb) / cpb];
            else                  eb = 1'b1;
            txv = get_tx(w);
            if (txv !== eb) errs++;
            if (k >= cpb && k < 9 * cpb && (k % cpb) == cpb / 2) got[(k - cpb) / cpb] = txv;
            @(negedge clk);
        end
        if (errs != 0) begin
            bad++;
            $display("FAIL %s: got byte %02h with %0d bad tx cycles, required %02h", nm, got, errs, exp);
        end
    endtask

    task automatic wait_done(input int w, input int t0, input int exp_dt, input string nm);
        int n;
        n = 0;
        while (get_done(w) !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (get_done(w) !== 1'b1) begin
            bad++;
            $display("FAIL %s_done: timeout, got no done, required done at +%0d", nm, exp_dt);
            return;
        end
        if (cyc - t0 !== exp_dt) begin
            bad++;
            $display("FAIL %s_done_time: got +%0d cycles, required +%0d", nm, cyc - t0, exp_dt);
        end
        total++;
        if (get_busy(w) !== 1'b0) begin
            bad++;
            $display("FAIL %s_busy_at_done: got %b, required 0", nm, get_busy(w));
        end
    endtask

    task automatic check_fetch_entry(input int w, input string nm);
        total++;
        if (get_busy(w) !== 1'b1 || get_re(w) !== 1'b1) begin
            bad++;
            $display("FAIL %s_fetch_entry: got busy=%b mem_re=%b, required 1 1", nm, get_busy(w), get_re(w));
        end
    endtask

    task automatic check_addrs(input int w, input int base, input logic [12:0] a0,
                               input int cnt, input string nm);
        int errs;
        logic [12:0] ea;
        errs = 0;
        ea = a0;
        total++;
        if (addr_size(w) - base !== cnt) begin
            bad++;
            $display("FAIL %s_addr_count: got %0d reads, required %0d", nm, addr_size(w) - base, cnt);
            return;
        end
        for (int i = 0; i < cnt; i++) begin
            if (addr_at(w, base + i) !== ea) errs++;
            ea = ea + 13'd1;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL %s_addr_seq: got first %0d, %0d wrong, required from %0d", nm,
                     addr_at(w, base), errs, a0);
        end
    endtask

    task automatic check_done_count(input int w, input int d0, input int exp, input string nm);
        total++;
        if (done_cnt[w] - d0 !== exp) begin
            bad++;
            $display("FAIL %s_done_count: got %0d pulses, required %0d", nm, done_cnt[w] - d0, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        total++;
        if (if_a.tx !== 1'b1 || if_a.busy !== 1'b0 || if_a.done !== 1'b0 || if_a.mem_re !== 1'b0) begin
            bad++;
            $display("FAIL reset_a_ctl: got tx=%b busy=%b done=%b re=%b, required 1 0 0 0",
                     if_a.tx, if_a.busy, if_a.done, if_a.mem_re);
        end
        total++;
        if (if_a.mem_raddr !== 13'd0 || if_w.mem_raddr !== 13'd0 || if_m.mem_raddr !== 13'd0) begin
            bad++;
            $display("FAIL reset_raddr: got %0d %0d %0d, required 0 0 0",
                     if_a.mem_raddr, if_w.mem_raddr, if_m.mem_raddr);
        end
        total++;
        if (if_w.tx !== 1'b1 || if_m.tx !== 1'b1 || if_w.busy !== 1'b0 || if_m.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_wm: got tx=%b%b busy=%b%b, required tx=11 busy=00",
                     if_w.tx, if_m.tx, if_w.busy, if_m.busy);
        end
    endtask

    task automatic test_basic();
        int t0;
        int ts [9];
        int base;
        int d0;
        int gerr;
        base = addr_size(0);
        d0 = done_cnt[0];
        gerr = 0;
        pulse_start(0, t0);
        check_fetch_entry(0, "basic");
        for (int i = 0; i < 8; i++) check_frame(0, 4, 8'(8'h10 + i), "basic_frame", ts[i]);
        if (CS == 1) check_frame(0, 4, 8'h00, "basic_csum_frame", ts[8]);
        if (ts[0] - t0 != 3) gerr++;
        for (int i = 1; i < 8 + CS; i++) begin
            if (ts[i] - ts[i - 1] != ((i == 8) ? 42 : 44)) gerr++;
        end
        total++;
        if (gerr != 0) begin
            bad++;
            $display("FAIL basic_frame_spacing: got %0d bad gaps, required 0", gerr);
        end
        wait_done(0, t0, 352 + 42 * CS, "basic");
        repeat (10) @(negedge clk);
        check_addrs(0, base, 13'd1, 8, "basic");
        check_done_count(0, d0, 1, "basic");
    endtask

    task automatic test_ignored_start();
        int t0;
        int tsx;
        int base;
        int d0;
        base = addr_size(0);
        d0 = done_cnt[0];
        pulse_start(0, t0);
        fork
            begin
                for (int i = 0; i < 8; i++) check_frame(0, 4, 8'(8'h10 + i), "ign_frame", tsx);
                if (CS == 1) check_frame(0, 4, 8'h00, "ign_csum_frame", tsx);
            end
            begin
                repeat (100) @(negedge clk);
                drive_start(0, 1'b1);
                @(negedge clk);
                drive_start(0, 1'b0);
            end
        join
        wait_done(0, t0, 352 + 42 * CS, "ign");
        repeat (20) @(negedge clk);
        check_addrs(0, base, 13'd1, 8, "ign");
        check_done_count(0, d0, 1, "ign");
    endtask

    task automatic test_wrap();
        int t0;
        int tsx;
        int base;
        base = addr_size(1);
        pulse_start(1, t0);
        check_fetch_entry(1, "wrap");
        check_frame(1, 4, 8'hA5, "wrap_frame0", tsx);
        check_frame(1, 4, 8'h3C, "wrap_frame1", tsx);
        if (CS == 1) check_frame(1, 4, 8'h99, "wrap_csum_frame", tsx);
        wait_done(1, t0, 88 + 42 * CS, "wrap");
        repeat (5) @(negedge clk);
        check_addrs(1, base, 13'd8191, 2, "wrap");
    endtask

    task automatic test_reset_midframe();
        int t0;
        int tsx;
        int d0;
        int base;
        pulse_start(0, t0);
        repeat (68) @(negedge clk);
        total++;
        if (if_a.busy !== 1'b1 || if_a.tx !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_before: got busy=%b tx=%b in frame 2 bit 4, required 1 1", if_a.busy, if_a.tx);
        end
        d0 = done_cnt[0];
        #1;
        rst = 1'b0;
        #1;
        total++;
        if (if_a.tx !== 1'b1 || if_a.busy !== 1'b0 || if_a.mem_re !== 1'b0 ||
            if_a.done !== 1'b0 || if_a.mem_raddr !== 13'd0) begin
            bad++;
            $display("FAIL rstmid_async: got tx=%b busy=%b re=%b done=%b raddr=%0d, required 1 0 0 0 0",
                     if_a.tx, if_a.busy, if_a.mem_re, if_a.done, if_a.mem_raddr);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (100) @(negedge clk);
        check_done_count(0, d0, 0, "rstmid_idle");
        total++;
        if (if_a.busy !== 1'b0 || if_a.tx !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_hold: got busy=%b tx=%b, required 0 1", if_a.busy, if_a.tx);
        end
        base = addr_size(0);
        pulse_start(0, t0);
        check_frame(0, 4, 8'h10, "replay_frame0", tsx);
        check_frame(0, 4, 8'h11, "replay_frame1", tsx);
        wait_done(0, t0, 352 + 42 * CS, "replay");
        check_addrs(0, base, 13'd1, 8, "replay");
    endtask

    task automatic test_min();
        int t0;
        int ts0;
        int tsx;
        pulse_start(2, t0);
        check_fetch_entry(2, "min");
        check_frame(2, 2, 8'hFF, "min_frame", ts0);
        total++;
        if (ts0 - t0 !== 3) begin
            bad++;
            $display("FAIL min_start_time: got +%0d, required +3", ts0 - t0);
        end
        if (CS == 1) check_frame(2, 2, 8'hFF, "min_csum_frame", tsx);
        wait_done(2, t0, 24 + 22 * CS, "min");
    endtask

    initial begin
        rst = 1'b0;
        if_a.start = 1'b0;
        if_w.start = 1'b0;
        if_m.start = 1'b0;
        if_a.mem_dout = '0;
        if_w.mem_dout = '0;
        if_m.mem_dout = '0;
        for (int i = 0; i < 3; i++) done_cnt[i] = 0;
        for (int i = 0; i < 8192; i++) begin
            mem_a[i] = 8'hEE;
            mem_w[i] = 8'hEE;
            mem_m[i] = 8'hEE;
        end
        for (int i = 0; i < 8; i++) mem_a[1 + i] = 8'(8'h10 + i);
        mem_w[8191] = 8'hA5;
        mem_w[0]    = 8'h3C;
        mem_m[1]    = 8'hFF;

        test_reset();
        test_basic();
        test_ignored_start();
        test_wrap();
        test_reset_midframe();
        test_min();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/result_reader.md
RESULT_READER -- requirements
Module: result_reader

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per UART bit (legal range 2..65535).
REQ-002 The module SHALL have parameter BASE_ADDR, default 1, meaning the first memory address read.
REQ-003 The module SHALL have parameter N_WORDS, default 8, meaning the number of bytes read and sent (legal range 1..8192).
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  single-cycle request to begin a readout.
REQ-007 mem_re  output  1  memory read enable.
REQ-008 mem_raddr  output  13  memory read address.
REQ-009 mem_dout  input  8  memory read data, valid exactly one clk after mem_re is sampled high.
REQ-010 tx  output  1  UART 8N1 serial line, LSB first, idle high.
REQ-011 busy  output  1  high from start acceptance until done.
REQ-012 done  output  1  one-cycle pulse when the last frame's stop bit ends.

Function
REQ-013 States SHALL be IDLE, FETCH, WAIT, LOAD, START, DATA, STOP, NEXT; with RESULT_READER_CHECKSUM_EN also CSUM.
REQ-014 In IDLE with start high, it SHALL load the address with BASE_ADDR, clear the word count, set busy, and go to FETCH.
REQ-015 In IDLE with start low, it SHALL stay in IDLE.
REQ-016 start SHALL be ignored while busy is high.
REQ-017 FETCH SHALL assert mem_re for exactly one cycle and go to WAIT; mem_re SHALL be low in all other states.
REQ-018 WAIT SHALL go to LOAD.
REQ-019 LOAD SHALL capture mem_dout into an 8-bit shift register and go to START.
REQ-020 START SHALL drive tx=0 for CLKS_PER_BIT cycles.
REQ-021 DATA SHALL drive shift-register bits 0..7 in order, CLKS_PER_BIT cycles each.
REQ-022 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles; one frame therefore lasts 10*CLKS_PER_BIT cycles.
REQ-023 NEXT SHALL increment the address modulo 2^13 (8191 wraps to 0) and the word count.
REQ-024 If the word count reaches N_WORDS, NEXT SHALL finish as in REQ-026 (or go to CSUM when the checksum is enabled); otherwise it SHALL go to FETCH.
REQ-025 The inter-frame gap (NEXT, FETCH, WAIT, LOAD) SHALL be exactly 4 cycles of tx=1.
REQ-026 On completion, done SHALL pulse for one cycle, busy SHALL fall in the same cycle, and the FSM SHALL return to IDLE.
REQ-027 The bit-timer SHALL be 16 bits wide and the word counter 14 bits wide.
REQ-028 tx SHALL be registered, with no combinational path from any input.

Reset
REQ-029 Asserting rst SHALL immediately force state=IDLE, tx=1, busy=0, done=0, mem_re=0, mem_raddr=0, shift register=0, counters=0, checksum=0, including mid-frame.
REQ-030 Outputs SHALL hold their reset values until the first start after rst deasserts.

Configuration
REQ-031 With macro RESULT_READER_CHECKSUM_EN defined, the module SHALL XOR each byte into an 8-bit checksum cleared at start acceptance.
REQ-032 With RESULT_READER_CHECKSUM_EN defined, after the last data frame it SHALL transmit one extra frame (CSUM) carrying the checksum, then signal done.
REQ-033 With RESULT_READER_CHECKSUM_EN undefined, no checksum logic SHALL exist and done SHALL follow the last data frame's stop bit.

Verification
REQ-034 Basic readout: CLKS_PER_BIT=4, BASE_ADDR=1, N_WORDS=8, memory[1..8]=0x10..0x17, start pulse.
- Required: 8 frames decode to 0x10..0x17 in order.
- Required: mem_raddr sequence 1..8.
- Required: done pulses 8*40+8*4 cycles after the FETCH entry (checksum disabled).
REQ-035 Checksum: REQ-034 setup with RESULT_READER_CHECKSUM_EN defined; required: a 9th frame equal to 0x00 (the XOR of 0x10..0x17), and done follows it.
REQ-036 Ignored start: a second start pulse during frame 3 of REQ-034; required: the byte stream and done timing are unchanged and exactly one done pulse occurs.
REQ-037 Address wrap: BASE_ADDR=8191, N_WORDS=2, memory[8191]=0xA5, memory[0]=0x3C; required: mem_raddr 8191 then 0, frames 0xA5 then 0x3C.
REQ-038 Reset mid-frame: rst low during DATA bit 4 of frame 2; required: tx=1, busy=0, state IDLE in the same cycle, and no done pulse.
- Required: a new start afterwards replays from BASE_ADDR.
REQ-039 Minimum parameters: N_WORDS=1, CLKS_PER_BIT=2, memory[1]=0xFF; required: a single 20-cycle frame 0,1×8,1, then done.
